// File: rtl/cam_pixel_capture.sv
// cam_pixel_capture
//   Camera (OV7670, pclk domain) to pixel-BRAM write path. Pairs camera bytes
//   into pixels (RGB565 or xRGB444 input, chosen per frame), decimates by
//   2^DECIM_LOG2 in both directions, produces linear write addresses, and
//   flags frames whose line lengths or line count differ from H_ACTIVE/V_ACTIVE.
//
//   Optional build macro: CAM_PIXEL_GRAY_EN
//     defined   - luma Y = (R8 + 2*G8 + B8) >> 2 is written to every output
//                 channel; one extra pipeline stage (write latency 2 cycles).
//     undefined - colour path, write latency 1 cycle.
module cam_pixel_capture #(
    parameter int OUT_WIDTH  = 12,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int DECIM_LOG2 = 2,
    parameter int ADDR_WIDTH = 19,
    parameter int FCNT_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rstn_clk,
    input  logic                  i_capture_en,
    input  logic                  i_fmt_565,
    input  logic [7:0]            i_pix_byte,
    input  logic                  i_vsync,
    input  logic                  i_href,
    output logic                  o_pix_wr,
    output logic [ADDR_WIDTH-1:0] o_pix_addr,
    output logic [OUT_WIDTH-1:0]  o_pix_data,
    output logic                  o_frame_done,
    output logic                  o_frame_err,
    output logic [FCNT_WIDTH-1:0] o_frame_cnt
);

    // One spare bit so an over-long line or frame can never wrap back into
    // the active window; the counters saturate at all-ones.
    localparam int COL_W = $clog2(H_ACTIVE + 1) + 1;
    localparam int ROW_W = $clog2(V_ACTIVE + 1) + 1;
    localparam int DMASK = (1 << DECIM_LOG2) - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    vsync_q, href_q;
    logic                    fmt_q, fmt_d;
    logic                    phase_q, phase_d;
    logic [7:0]              byte0_q, byte0_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic                    err_q, err_d;
    logic [FCNT_WIDTH-1:0]   fcnt_q, fcnt_d;
    logic                    wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [OUT_WIDTH-1:0]    data_q, data_d;
    logic                    done_q, done_d;
    logic                    ferr_q, ferr_d;

    logic vs_rise, vs_fall, href_fall, keep;

    assign vs_rise   =  i_vsync & ~vsync_q;
    assign vs_fall   = ~i_vsync &  vsync_q;
    assign href_fall = ~i_href  &  href_q;

    // A completed pixel is written only inside the active window and on the
    // decimation grid in both directions.
    assign keep = (col_q < COL_W'(H_ACTIVE)) && (row_q < ROW_W'(V_ACTIVE)) &&
                  ((col_q & COL_W'(DMASK)) == '0) &&
                  ((row_q & ROW_W'(DMASK)) == '0);

    // Unpack the stored first byte and the current second byte into 565
    // channels; 444 input is widened by replicating channel MSBs.
    logic [4:0] r5, b5;
    logic [5:0] g6;
    always_comb begin
        if (fmt_q) begin
            r5 = byte0_q[7:3];
            g6 = {byte0_q[2:0], i_pix_byte[7:5]};
            b5 = i_pix_byte[4:0];
        end else begin
            r5 = {byte0_q[3:0], byte0_q[3]};
            g6 = {i_pix_byte[7:4], i_pix_byte[7:6]};
            b5 = {i_pix_byte[3:0], i_pix_byte[3]};
        end
    end

`ifdef CAM_PIXEL_GRAY_EN
    // Luma stage: channels scaled to 8 bits per input format, 10-bit sum.
    logic [7:0]            r8, g8, b8, y_new;
    logic [9:0]            ysum;
    logic                  v1_q, v1_d;
    logic [7:0]            y1_q, y1_d;
    logic [ADDR_WIDTH-1:0] a1_q, a1_d;
    logic [OUT_WIDTH-1:0]  pix_gray;

    // Per-format scale-up to 8 bits, then the weighted luma sum.
    always_comb begin
        if (fmt_q) begin
            r8 = {byte0_q[7:3], byte0_q[7:5]};
            g8 = {byte0_q[2:0], i_pix_byte[7:5], byte0_q[2:1]};
            b8 = {i_pix_byte[4:0], i_pix_byte[4:2]};
        end else begin
            r8 = {byte0_q[3:0], byte0_q[3:0]};
            g8 = {i_pix_byte[7:4], i_pix_byte[7:4]};
            b8 = {i_pix_byte[3:0], i_pix_byte[3:0]};
        end
        ysum  = {2'b00, r8} + {1'b0, g8, 1'b0} + {2'b00, b8};
        y_new = ysum[9:2];
    end

    if (OUT_WIDTH == 16) begin : g_gray16
        assign pix_gray = {y1_q[7:3], y1_q[7:2], y1_q[7:3]};
    end else begin : g_gray12
        assign pix_gray = {y1_q[7:4], y1_q[7:4], y1_q[7:4]};
    end
`else
    logic [OUT_WIDTH-1:0] pix_color;

    if (OUT_WIDTH == 16) begin : g_col16
        assign pix_color = {r5, g6, b5};
    end else begin : g_col12
        assign pix_color = {r5[4:1], g6[5:2], b5[4:1]};
    end
`endif

    // Next-state: capture FSM, byte pairing, line/frame accounting, write stage.
    always_comb begin
        state_d = state_q;
        fmt_d   = fmt_q;
        phase_d = phase_q;
        byte0_d = byte0_q;
        col_d   = col_q;
        row_d   = row_q;
        waddr_d = waddr_q;
        err_d   = err_q;
        fcnt_d  = fcnt_q;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
`ifdef CAM_PIXEL_GRAY_EN
        v1_d    = 1'b0;
        y1_d    = y1_q;
        a1_d    = a1_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_capture_en) state_d = SYNC;
            end
            SYNC: begin
                if (vs_fall) begin
                    if (i_capture_en) begin
                        fmt_d   = i_fmt_565;
                        col_d   = '0;
                        row_d   = '0;
                        waddr_d = '0;
                        phase_d = 1'b0;
                        err_d   = 1'b0;
                        state_d = ACTIVE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            ACTIVE: begin
                if (vs_rise) begin
                    // Frame end wins over any coincident href activity.
                    done_d  = 1'b1;
                    ferr_d  = err_q | (row_q != ROW_W'(V_ACTIVE));
                    fcnt_d  = fcnt_q + FCNT_WIDTH'(1);
                    state_d = SYNC;
                end else if (i_href) begin
                    phase_d = ~phase_q;
                    if (!phase_q) begin
                        byte0_d = i_pix_byte;
                    end else begin
                        if (col_q != '1) col_d = col_q + COL_W'(1);
                        if (keep) begin
`ifdef CAM_PIXEL_GRAY_EN
                            v1_d = 1'b1;
                            y1_d = y_new;
                            a1_d = waddr_q;
`else
                            wr_d   = 1'b1;
                            data_d = pix_color;
                            addr_d = waddr_q;
`endif
                            waddr_d = waddr_q + ADDR_WIDTH'(1);
                        end
                    end
                end else if (href_fall) begin
                    if (col_q != COL_W'(H_ACTIVE) || phase_q) err_d = 1'b1;
                    if (row_q != '1) row_d = row_q + ROW_W'(1);
                    col_d   = '0;
                    phase_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef CAM_PIXEL_GRAY_EN
        if (v1_q) begin
            wr_d   = 1'b1;
            data_d = pix_gray;
            addr_d = a1_q;
        end
`endif
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rstn_clk) begin
            state_q <= IDLE;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            fmt_q   <= 1'b0;
            phase_q <= 1'b0;
            byte0_q <= '0;
            col_q   <= '0;
            row_q   <= '0;
            waddr_q <= '0;
            err_q   <= 1'b0;
            fcnt_q  <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef CAM_PIXEL_GRAY_EN
            v1_q    <= 1'b0;
            y1_q    <= '0;
            a1_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            vsync_q <= i_vsync;
            href_q  <= i_href;
            fmt_q   <= fmt_d;
            phase_q <= phase_d;
            byte0_q <= byte0_d;
            col_q   <= col_d;
            row_q   <= row_d;
            waddr_q <= waddr_d;
            err_q   <= err_d;
            fcnt_q  <= fcnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
`ifdef CAM_PIXEL_GRAY_EN
            v1_q    <= v1_d;
            y1_q    <= y1_d;
            a1_q    <= a1_d;
`endif
        end
    end

    assign o_pix_wr     = wr_q;
    assign o_pix_addr   = addr_q;
    assign o_pix_data   = data_q;
    assign o_frame_done = done_q;
    assign o_frame_err  = ferr_q;
    assign o_frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_cam_pixel_capture.sv
// tb_cam_pixel_capture
//   Two instances share the camera inputs: dut0 (12-bit out, 4x2, no
//   decimation) and dut1 (16-bit out, 4x4, decimate by 2). Every frame is
//   described as a table of lines/bytes; a frame-level model derives the
//   expected writes, done/err pulse and frame count for each instance.
module tb_cam_pixel_capture;
    typedef longint lq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn, en, fmt, vsync, href;
    logic [7:0] pb;

    logic        wr0, dn0, er0;
    logic [18:0] a0;
    logic [11:0] d0;
    logic [7:0]  c0;
    logic        wr1, dn1, er1;
    logic [18:0] a1;
    logic [15:0] d1;
    logic [7:0]  c1;

    cam_pixel_capture #(.OUT_WIDTH(12), .H_ACTIVE(4), .V_ACTIVE(2), .DECIM_LOG2(0),
                        .ADDR_WIDTH(19), .FCNT_WIDTH(8)) dut0 (
        .i_clk(clk), .i_rstn_clk(rstn), .i_capture_en(en), .i_fmt_565(fmt),
        .i_pix_byte(pb), .i_vsync(vsync), .i_href(href),
        .o_pix_wr(wr0), .o_pix_addr(a0), .o_pix_data(d0),
        .o_frame_done(dn0), .o_frame_err(er0), .o_frame_cnt(c0));

    cam_pixel_capture #(.OUT_WIDTH(16), .H_ACTIVE(4), .V_ACTIVE(4), .DECIM_LOG2(1),
                        .ADDR_WIDTH(19), .FCNT_WIDTH(8)) dut1 (
        .i_clk(clk), .i_rstn_clk(rstn), .i_capture_en(en), .i_fmt_565(fmt),
        .i_pix_byte(pb), .i_vsync(vsync), .i_href(href),
        .o_pix_wr(wr1), .o_pix_addr(a1), .o_pix_data(d1),
        .o_frame_done(dn1), .o_frame_err(er1), .o_frame_cnt(c1));

    // Observed writes {addr,data} and frame-done events {err,cnt}, sampled mid-cycle.
    lq_t wq0, wq1, dq0, dq1;
    always @(negedge clk) begin
        if (wr0) wq0.push_back((longint'(a0) << 16) | longint'(d0));
        if (dn0) dq0.push_back((longint'(er0) << 8) | longint'(c0));
        if (wr1) wq1.push_back((longint'(a1) << 16) | longint'(d1));
        if (dn1) dq1.push_back((longint'(er1) << 8) | longint'(c1));
    end

    int checks = 0;
    int errors = 0;
    int fb[8][32];
    int ll[8];
    int nl;
    int ecnt;
    int bw0, bw1, bd0, bd1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pixel value from the format rules: channels widened to 565 by MSB
    // replication, narrowed to 444 by keeping MSBs; luma when grayscale.
    function automatic int conv(input int b0, input int b1, input bit f, input int ow);
        int r, g, b, r8, g8, b8, y;
        if (f) begin
            r = b0 / 8;  g = (b0 % 8) * 8 + b1 / 32;  b = b1 % 32;
            r8 = r * 8 + r / 4;  g8 = g * 4 + g / 16;  b8 = b * 8 + b / 4;
        end else begin
            r8 = (b0 % 16) * 17;  g8 = (b1 / 16) * 17;  b8 = (b1 % 16) * 17;
            r = (b0 % 16) * 2 + (b0 % 16) / 8;
            g = (b1 / 16) * 4 + (b1 / 16) / 4;
            b = (b1 % 16) * 2 + (b1 % 16) / 8;
        end
`ifdef CAM_PIXEL_GRAY_EN
        y = (r8 + 2 * g8 + b8) / 4;
        if (ow == 16) return (y / 8) * 2048 + (y / 4) * 32 + (y / 8);
        return (y / 16) * 273;
`else
        y = r8 + g8 + b8;
        if (ow == 16) return r * 2048 + g * 32 + b + 0 * y;
        return (r / 2) * 256 + (g / 4) * 16 + (b / 2);
`endif
    endfunction

    task automatic check_dut(input string tag, input int H, input int V, input int D,
                             input int OW, input lq_t wq, input int wb, input lq_t dq,
                             input int db, input bit cap, input int live_cnt);
        lq_t exp;
        bit  err;
        int  step;
        step = 1 << D;
        err  = (nl != V);
        if (cap) begin
            for (int r = 0; r < nl; r++) begin
                if (ll[r] != 2 * H) err = 1'b1;
                for (int c = 0; c < ll[r] / 2; c++)
                    if (c < H && r < V && c % step == 0 && r % step == 0)
                        exp.push_back((longint'(exp.size()) << 16) |
                                      longint'(conv(fb[r][2*c], fb[r][2*c+1], fmt, OW)));
            end
        end
        chk({tag, ".nwr"}, longint'(wq.size() - wb), longint'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            if (wb + i < wq.size()) chk({tag, ".wr"}, wq[wb+i], exp[i]);
        chk({tag, ".ndone"}, longint'(dq.size() - db), cap ? 64'd1 : 64'd0);
        if (cap && dq.size() > db)
            chk({tag, ".err_cnt"}, dq[db], (longint'(err) << 8) | longint'(ecnt % 256));
        chk({tag, ".cnt"}, longint'(live_cnt), longint'(ecnt % 256));
    endtask

    task automatic fill_const(input int n, input int b0, input int b1);
        nl = n;
        for (int l = 0; l < n; l++) begin
            ll[l] = 8;
            for (int k = 0; k < 4; k++) begin
                fb[l][2*k] = b0;  fb[l][2*k+1] = b1;
            end
        end
    endtask

    task automatic fill_rand(input int n);
        nl = n;
        for (int l = 0; l < n; l++) begin
            ll[l] = 8;
            for (int k = 0; k < 8; k++) fb[l][k] = int'($urandom_range(0, 255));
        end
    endtask

    // Drives one vsync-bounded frame; optional reset pulse at (rst_line,rst_byte)
    // and capture-enable drop at the start of drop_line.
    task automatic send_frame(input int rst_line, input int rst_byte, input int drop_line);
        for (int t = 0; t < 3; t++) tick();
        vsync = 1'b0;
        tick();
        tick();
        for (int l = 0; l < nl; l++) begin
            if (l == drop_line) en = 1'b0;
            for (int b = 0; b < ll[l]; b++) begin
                if (l == rst_line && b == rst_byte) begin
                    rstn = 1'b0;
                    tick();
                    tick();
                    rstn = 1'b1;
                    bw0 = wq0.size();  bw1 = wq1.size();
                    bd0 = dq0.size();  bd1 = dq1.size();
                end
                href = 1'b1;
                pb   = 8'(fb[l][b]);
                tick();
            end
            href = 1'b0;
            pb   = 8'h00;
            for (int t = 0; t < 3; t++) tick();
        end
        vsync = 1'b1;
        for (int t = 0; t < 5; t++) tick();
    endtask

    task automatic run_frame(input string tag, input bit cap, input int rst_line,
                             input int rst_byte, input int drop_line);
        bw0 = wq0.size();  bw1 = wq1.size();
        bd0 = dq0.size();  bd1 = dq1.size();
        send_frame(rst_line, rst_byte, drop_line);
        if (rst_line >= 0) ecnt = 0;
        if (cap) ecnt++;
        check_dut({tag, ".d0"}, 4, 2, 0, 12, wq0, bw0, dq0, bd0, cap, int'(c0));
        check_dut({tag, ".d1"}, 4, 4, 1, 16, wq1, bw1, dq1, bd1, cap, int'(c1));
    endtask

    initial begin
        rstn = 1'b0;  en = 1'b0;  fmt = 1'b0;
        vsync = 1'b1; href = 1'b0; pb = 8'h00;
        ecnt = 0;
        repeat (3) tick();
        chk("rst.wr0", longint'(wr0), 0);   chk("rst.addr0", longint'(a0), 0);
        chk("rst.data0", longint'(d0), 0);  chk("rst.done0", longint'(dn0), 0);
        chk("rst.err0", longint'(er0), 0);  chk("rst.cnt0", longint'(c0), 0);
        chk("rst.wr1", longint'(wr1), 0);   chk("rst.addr1", longint'(a1), 0);
        chk("rst.data1", longint'(d1), 0);  chk("rst.done1", longint'(dn1), 0);
        chk("rst.err1", longint'(er1), 0);  chk("rst.cnt1", longint'(c1), 0);
        rstn = 1'b1;
        en   = 1'b1;
        tick();

        // Directed colour patterns.
        fmt = 1'b0;  fill_const(2, 8'h0F, 8'h00);  run_frame("f444", 1, -1, 0, -1);
        fmt = 1'b1;  fill_const(2, 8'hF8, 8'h1F);  run_frame("f565", 1, -1, 0, -1);
        fmt = 1'b0;  fill_const(4, 8'h0A, 8'h5C);  run_frame("f444x4", 1, -1, 0, -1);

        // Random frames, random format, 2 or 4 lines.
        for (int i = 0; i < 4; i++) begin
            fmt = 1'($urandom_range(0, 1));
            fill_rand((i % 2 == 0) ? 4 : 2);
            run_frame("rand", 1, -1, 0, -1);
        end

        // Short line flags an error; the following clean frame does not.
        fmt = 1'b1;  fill_rand(2);  ll[1] = 6;
        run_frame("short", 1, -1, 0, -1);
        fill_rand(2);
        run_frame("clean", 1, -1, 0, -1);

        // Reset in the middle of line 0: nothing from that frame, then restart at 0.
        fmt = 1'b0;  fill_rand(2);
        run_frame("rstmid", 0, 0, 3, -1);
        fill_rand(4);
        run_frame("afterrst", 1, -1, 0, -1);

        // Enable dropped mid-frame: that frame completes, the next is ignored.
        fill_rand(2);
        run_frame("drop", 1, -1, 0, 1);
        fill_rand(2);
        run_frame("dropped", 0, -1, 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
